// File: rtl/fwrisc_operand_fetch_pkg.sv
// Shared widths and stage record for the operand-fetch pipeline.
package fwrisc_operand_fetch_pkg;

  localparam int REG_AW    = 6;
  localparam int OPF_TAG_W = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 valid;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [OPF_TAG_W-1:0] tag;
  } opf_stage_t;

endpackage

// File: rtl/fwrisc_operand_fetch_if.sv
// Decode-side and execute-side handshakes of the operand-fetch stage.
// The stage uses the slave view; decode/execute (or a bench) uses master.
interface fwrisc_operand_fetch_if #(
  parameter int RAW   = 6,
  parameter int TAG_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [RAW-1:0]   in_rs1;
  logic [RAW-1:0]   in_rs2;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_op_a;
  logic [31:0]      out_op_b;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_op_a, out_op_b, out_tag
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_op_a, out_op_b, out_tag
  );

endinterface

// File: rtl/fwrisc_operand_fetch_bypass.sv
// Writeback forwarding mux for one operand: x0 always reads as zero,
// otherwise a matching same-cycle write wins over the stored/read value.
module fwrisc_operand_fetch_bypass
  import fwrisc_operand_fetch_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter bit EN = 1'b1
) (
  input  logic [AW-1:0] addr,
  input  logic [31:0]   rdata,
  input  logic [AW-1:0] rd_waddr,
  input  logic [31:0]   rd_wdata,
  input  logic          rd_wen,
  output logic [31:0]   data
);

  // Select zero, forwarded write data, or the supplied value.
  always_comb begin
    data = rdata;
    if (addr == AW'(REG_ZERO)) begin
      data = '0;
    end else if (EN && rd_wen && (rd_waddr == addr)) begin
      data = rd_wdata;
    end
  end

endmodule

// File: rtl/fwrisc_operand_fetch.sv
// Operand-fetch stage: S1 holds the register-file read in flight, S2 is the
// output register towards execute. Full throughput, flushable, and operands
// stay fresh against writeback while either stage is stalled.
module fwrisc_operand_fetch
  import fwrisc_operand_fetch_pkg::*;
#(
  parameter int RAW       = REG_AW,
  parameter int TAG_W     = OPF_TAG_W,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  fwrisc_operand_fetch_if.slave bus,
  output logic [RAW-1:0]        ra_raddr,
  input  logic [31:0]           ra_rdata,
  output logic [RAW-1:0]        rb_raddr,
  input  logic [31:0]           rb_rdata,
  input  logic [RAW-1:0]        rd_waddr,
  input  logic [31:0]           rd_wdata,
  input  logic                  rd_wen
);

  opf_stage_t        s1_q;
  opf_stage_t        s2_q;
  logic [31:0]       op_a_q;
  logic [31:0]       op_b_q;

  logic [31:0]       s1_op_a;
  logic [31:0]       s1_op_b;
  logic [31:0]       s2_op_a;
  logic [31:0]       s2_op_b;

  logic              s2_free;
  logic              s1_adv;
  logic              in_fire;
  logic [REG_AW-1:0] wb_addr;

  assign wb_addr = REG_AW'(rd_waddr);

  // Handshake: S1 may move on whenever S2 is empty or draining this cycle.
  assign s2_free      = !s2_q.valid || bus.out_ready;
  assign s1_adv       = s1_q.valid && s2_free;
  assign bus.in_ready = !flush && (!s1_q.valid || s1_adv);
  assign in_fire      = bus.in_valid && bus.in_ready;

  // A held S1 keeps re-driving its addresses so the read tracks new writes.
  assign ra_raddr = in_fire ? bus.in_rs1 : RAW'(s1_q.rs1);
  assign rb_raddr = in_fire ? bus.in_rs2 : RAW'(s1_q.rs2);

  assign bus.out_valid = s2_q.valid;
  assign bus.out_op_a  = op_a_q;
  assign bus.out_op_b  = op_b_q;
  assign bus.out_tag   = TAG_W'(s2_q.tag);

  fwrisc_operand_fetch_bypass #(.AW(REG_AW), .EN(BYPASS_EN)) u_s1_a (
    .addr     (s1_q.rs1),
    .rdata    (ra_rdata),
    .rd_waddr (wb_addr),
    .rd_wdata (rd_wdata),
    .rd_wen   (rd_wen),
    .data     (s1_op_a)
  );

  fwrisc_operand_fetch_bypass #(.AW(REG_AW), .EN(BYPASS_EN)) u_s1_b (
    .addr     (s1_q.rs2),
    .rdata    (rb_rdata),
    .rd_waddr (wb_addr),
    .rd_wdata (rd_wdata),
    .rd_wen   (rd_wen),
    .data     (s1_op_b)
  );

  // The S2 hold update is a correctness path, so it is always enabled.
  fwrisc_operand_fetch_bypass #(.AW(REG_AW), .EN(1'b1)) u_s2_a (
    .addr     (s2_q.rs1),
    .rdata    (op_a_q),
    .rd_waddr (wb_addr),
    .rd_wdata (rd_wdata),
    .rd_wen   (rd_wen),
    .data     (s2_op_a)
  );

  fwrisc_operand_fetch_bypass #(.AW(REG_AW), .EN(1'b1)) u_s2_b (
    .addr     (s2_q.rs2),
    .rdata    (op_b_q),
    .rd_waddr (wb_addr),
    .rd_wdata (rd_wdata),
    .rd_wen   (rd_wen),
    .data     (s2_op_b)
  );

  // S1 register: capture on accept, empty when it advances, flush wins.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q <= '0;
    end else if (flush) begin
      s1_q.valid <= 1'b0;
    end else if (in_fire) begin
      s1_q.valid <= 1'b1;
      s1_q.rs1   <= REG_AW'(bus.in_rs1);
      s1_q.rs2   <= REG_AW'(bus.in_rs2);
      s1_q.tag   <= OPF_TAG_W'(bus.in_tag);
    end else if (s1_adv) begin
      s1_q.valid <= 1'b0;
    end
  end

  // S2 register: load from S1, drain on transfer, refresh operands while held.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s2_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (flush) begin
      s2_q.valid <= 1'b0;
    end else if (s1_adv) begin
      s2_q   <= s1_q;
      op_a_q <= s1_op_a;
      op_b_q <= s1_op_b;
    end else if (bus.out_ready) begin
      s2_q.valid <= 1'b0;
    end else if (s2_q.valid) begin
      op_a_q <= s2_op_a;
      op_b_q <= s2_op_b;
    end
  end

endmodule

// File: tb/tb_fwrisc_operand_fetch.sv
// Bench for fwrisc_operand_fetch: a register file (registered address,
// asynchronous read) plus a transaction-level model of the stage. The model
// tracks accepted instructions in a queue and expects every presented
// operand to equal the current architectural register value (x0 reads 0).
module tb_fwrisc_operand_fetch;

  logic        clock;
  logic        reset;
  logic        rst_next;
  logic        flush;
  logic [5:0]  ra_raddr;
  logic [31:0] ra_rdata;
  logic [5:0]  rb_raddr;
  logic [31:0] rb_rdata;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  fwrisc_operand_fetch_if #(.RAW(6), .TAG_W(32)) bus();

  fwrisc_operand_fetch #(.RAW(6), .TAG_W(32), .BYPASS_EN(1'b1)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .bus      (bus),
    .ra_raddr (ra_raddr),
    .ra_rdata (ra_rdata),
    .rb_raddr (rb_raddr),
    .rb_rdata (rb_rdata),
    .rd_waddr (rd_waddr),
    .rd_wdata (rd_wdata),
    .rd_wen   (rd_wen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: address registered at the edge, read asynchronously.
  logic [31:0] rf [64];
  logic [5:0]  ra_q;
  logic [5:0]  rb_q;

  always @(posedge clock) begin
    ra_q <= ra_raddr;
    rb_q <= rb_raddr;
    if (rd_wen) rf[rd_waddr] <= rd_wdata;
  end

  assign ra_rdata = rf[ra_q];
  assign rb_rdata = rf[rb_q];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] regval(input logic [5:0] a);
    return (a == 6'd0) ? 32'h0 : rf[a];
  endfunction

  // Transaction model
  typedef struct {
    logic [31:0] tag;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    int          acc;
  } txn_t;

  txn_t q[$];
  int   last_pop = -100;
  bit   model_on = 1'b0;

  // Compare the DUT against the model every cycle, then advance the model.
  always @(negedge clock) begin : cmp
    logic exp_ready;
    logic exp_valid;
    if (!reset) begin
      q.delete();
      last_pop = -100;
      model_on = 1'b1;
    end else if (model_on) begin
      exp_ready = !flush && ((q.size() < 2) || bus.out_ready);
      exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 2) && (cyc >= last_pop + 1);
      checkOutput("model_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
      checkOutput("model_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
      if (exp_valid && bus.out_valid) begin
        checkOutput("model_out_tag", bus.out_tag, q[0].tag);
        checkOutput("model_op_a", bus.out_op_a, regval(q[0].rs1));
        checkOutput("model_op_b", bus.out_op_b, regval(q[0].rs2));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && bus.out_ready) begin
          void'(q.pop_front());
          last_pop = cyc;
        end
        if (bus.in_valid && exp_ready) begin
          q.push_back('{tag: bus.in_tag, rs1: bus.in_rs1, rs2: bus.in_rs2, acc: cyc});
        end
      end
    end
    cyc++;
  end

  // One cycle: inputs change just after the edge, returns mid-cycle for checks.
  task automatic applyStimulus(input logic iv, input logic [5:0] r1, input logic [5:0] r2,
                               input logic [31:0] tg, input logic ordy, input logic fl,
                               input logic wen, input logic [5:0] wa, input logic [31:0] wd);
    @(posedge clock);
    #1;
    reset         = rst_next;
    bus.in_valid  = iv;
    bus.in_rs1    = r1;
    bus.in_rs2    = r2;
    bus.in_tag    = tg;
    bus.out_ready = ordy;
    flush         = fl;
    rd_wen        = wen;
    rd_waddr      = wa;
    rd_wdata      = wd;
    @(negedge clock);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first;
    int nvalid;
    reset         = 1'b0;
    rst_next      = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    rd_wen        = 1'b0;
    rd_waddr      = '0;
    rd_wdata      = '0;

    $display("[TB] reset");
    idle();
    idle();
    rst_next = 1'b1;
    idle();
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_op_a", bus.out_op_a, 32'h0);
    checkOutput("rst_op_b", bus.out_op_b, 32'h0);
    checkOutput("rst_tag", bus.out_tag, 32'h0);

    // Preload x_i = 0x100+i, then x5 and the CSR shadow entry x40.
    for (int i = 1; i < 64; i++) begin
      applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'(i), 32'h100 + 32'(i));
    end
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd5, 32'h1234);
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd40, 32'hC5C50040);
    idle();

    $display("[TB] basic read");
    applyStimulus(1'b1, 6'd5, 6'd0, 32'hC0DE0001, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    idle();
    idle();
    checkOutput("t1_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("t1_op_a", bus.out_op_a, 32'h1234);
    checkOutput("t1_op_b", bus.out_op_b, 32'h0);
    checkOutput("t1_tag", bus.out_tag, 32'hC0DE0001);

    $display("[TB] S1 bypass");
    applyStimulus(1'b1, 6'd7, 6'd5, 32'hC0DE0002, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd7, 32'h0000DEAD);
    idle();
    checkOutput("t2_op_a", bus.out_op_a, 32'h0000DEAD);
    checkOutput("t2_op_b", bus.out_op_b, 32'h1234);

    $display("[TB] output stall");
    applyStimulus(1'b1, 6'd7, 6'd3, 32'hC0DE0003, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b1, 6'd9, 6'd7, 32'hC0DE0004, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b1, 6'd1, 6'd2, 32'hC0DE0005, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    checkOutput("t3_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("t3_op_a_before", bus.out_op_a, 32'h0000DEAD);
    applyStimulus(1'b1, 6'd1, 6'd2, 32'hC0DE0005, 1'b0, 1'b0, 1'b1, 6'd7, 32'h0000BEEF);
    applyStimulus(1'b1, 6'd1, 6'd2, 32'hC0DE0005, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    checkOutput("t3_op_a_held", bus.out_op_a, 32'h0000BEEF);
    checkOutput("t3_tag_held", bus.out_tag, 32'hC0DE0003);
    applyStimulus(1'b1, 6'd1, 6'd2, 32'hC0DE0005, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    checkOutput("t3_op_a_release", bus.out_op_a, 32'h0000BEEF);
    checkOutput("t3_op_b_release", bus.out_op_b, 32'h103);
    checkOutput("t3_in_ready_release", {31'd0, bus.in_ready}, 32'd1);
    idle();
    checkOutput("t3_s1_op_a", bus.out_op_a, 32'h109);
    checkOutput("t3_s1_op_b", bus.out_op_b, 32'h0000BEEF);
    idle();
    checkOutput("t3_last_tag", bus.out_tag, 32'hC0DE0005);
    idle();
    idle();

    $display("[TB] back-to-back");
    first  = -1;
    nvalid = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        applyStimulus(1'b1, 6'(k + 1), 6'(20 + k), 32'hA0 + 32'(k), 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
      end else begin
        idle();
      end
      if (bus.out_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = k;
      end
    end
    checkOutput("t4_valid_count", 32'(nvalid), 32'd8);
    checkOutput("t4_first_valid", 32'(first), 32'd2);

    $display("[TB] x0 and CSR shadow");
    applyStimulus(1'b1, 6'd0, 6'd40, 32'hC0DE0006, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd0, 32'hFFFFFFFF);
    idle();
    checkOutput("t5_x0_op_a", bus.out_op_a, 32'h0);
    checkOutput("t5_csr_op_b", bus.out_op_b, 32'hC5C50040);
    applyStimulus(1'b1, 6'd40, 6'd0, 32'hC0DE0007, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b1, 6'd40, 32'hC5C5F00D);
    idle();
    checkOutput("t5_csr_bypass", bus.out_op_a, 32'hC5C5F00D);
    checkOutput("t5_x0_op_b", bus.out_op_b, 32'h0);
    idle();
    idle();

    $display("[TB] flush");
    applyStimulus(1'b1, 6'd5, 6'd9, 32'hC0DE0008, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b1, 6'd9, 6'd5, 32'hC0DE0009, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b1, 6'd3, 6'd3, 32'hC0DE000A, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0);
    checkOutput("t6_flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    idle();
    checkOutput("t6_flush_valid", {31'd0, bus.out_valid}, 32'd0);
    idle();
    checkOutput("t6_flush_dropped", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 6'd5, 6'd9, 32'hC0DE000B, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    applyStimulus(1'b1, 6'd3, 6'd1, 32'hC0DE000C, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    rst_next = 1'b0;
    applyStimulus(1'b0, 6'd0, 6'd0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
    checkOutput("t6_stalled_valid", {31'd0, bus.out_valid}, 32'd1);
    checkOutput("t6_stalled_op_a", bus.out_op_a, 32'h1234);
    rst_next = 1'b1;
    idle();
    checkOutput("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("t6_rst_op_a", bus.out_op_a, 32'h0);
    checkOutput("t6_rst_op_b", bus.out_op_b, 32'h0);
    checkOutput("t6_rst_tag", bus.out_tag, 32'h0);
    checkOutput("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    idle();
    checkOutput("t6_rst_s1_empty", {31'd0, bus.out_valid}, 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
